// File: rtl/mux_16_pkg.sv
// Shared Hack datapath definitions.
//   HACK_WORD_W : width of a Hack machine word.
//   hack_word_t : one Hack word. The ALU, the registers and the PC also use this type.
package mux_16_pkg;

   localparam int HACK_WORD_W = 16;

   typedef logic [HACK_WORD_W-1:0] hack_word_t;

endpackage : mux_16_pkg

// File: rtl/mux_1.sv
// Single-bit 2:1 multiplexer built only from NAND/NOT gates.
// Ports:
//   a   : data input, selected when sel=0
//   b   : data input, selected when sel=1
//   sel : select
//   out : (a & ~sel) | (b & sel)
module mux_1 (
   input  logic a,
   input  logic b,
   input  logic sel,
   output logic out
);

   logic nsel;
   logic a_n;
   logic b_n;

   // The final NAND of the two inverted terms gives an OR of the two
   // qualified inputs (De Morgan).
   assign nsel = ~sel;
   assign a_n  = ~(a & nsel);
   assign b_n  = ~(b & sel);
   assign out  = ~(a_n & b_n);

endmodule : mux_1

// File: rtl/mux_16.sv
// 16-bit 2:1 word multiplexer for the Hack datapath. It is used for A/M select,
// the ALU input and the PC source.
// Ports:
//   clk       : clock; only the capture register uses it
//   rst_n     : async active-low clear of the capture register
//   a, b      : data words; sel=0 selects a, sel=1 selects b
//   sel       : select, shared by every bit slice
//   en        : capture enable for out_q
//   out       : combinational result, sel ? b : a. Clock and reset do not affect it.
//   out_q     : registered copy of out, loaded on enabled edges
//   out_valid : high for the cycle after each capture
module mux_16
   import mux_16_pkg::*;
#(
   parameter int WIDTH = HACK_WORD_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sel,
   input  logic             en,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] out_q,
   output logic             out_valid
);

   // One gate-level slice per bit. All slices share sel.
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      mux_1 u_mux_1 (
         .a   (a[i]),
         .b   (b[i]),
         .sel (sel),
         .out (out[i])
      );
   end

   // Capture register. out_valid is a single-cycle strobe. When en is low,
   // out_q holds its value but the strobe drops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q     <= '0;
         out_valid <= 1'b0;
      end else if (en) begin
         out_q     <= out;
         out_valid <= 1'b1;
      end else begin
         out_valid <= 1'b0;
      end
   end

endmodule : mux_16

// File: tb/tb_mux_16.sv
// Self-checking bench for mux_16.
// The bench issues stimulus and pushes expected captures into a queue.
// A separate monitor pops one entry each time out_valid is high.
module tb_mux_16;
   import mux_16_pkg::*;

   logic       clk;
   logic       rst_n;
   hack_word_t a;
   hack_word_t b;
   logic       sel;
   logic       en;
   hack_word_t out;
   hack_word_t out_q;
   logic       out_valid;

   int checks = 0;
   int errors = 0;

   hack_word_t exp_q[$];   // expected captures, in order
   hack_word_t mdl_q;      // reference model of the register contents
   logic       mdl_v;

   mux_16 #(.WIDTH(HACK_WORD_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .a         (a),
      .b         (b),
      .sel       (sel),
      .en        (en),
      .out       (out),
      .out_q     (out_q),
      .out_valid (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Higher-level reference for the combinational path: a plain word select.
   function automatic hack_word_t ref_mux(input hack_word_t x, input hack_word_t y, input logic s);
      return s ? y : x;
   endfunction

   // Reference register behaviour at a rising edge. Inputs are read before the edge settles.
   task automatic edge_model();
      @(posedge clk);
      if (rst_n) begin
         if (en) begin
            mdl_q = ref_mux(a, b, sel);
            mdl_v = 1'b1;
            exp_q.push_back(mdl_q);
         end else begin
            mdl_v = 1'b0;
         end
      end
   endtask

   // Monitor: each out_valid cycle must match the oldest expected capture.
   initial begin
      forever begin
         @(negedge clk);
         if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL mon_unexpected: out_valid with out_q=%h, nothing expected at %0t", out_q, $time);
            end else begin
               check("mon_out_q", 32'(out_q), 32'(exp_q.pop_front()));
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      en    = 1'b0;
      a     = 16'hAAAA;
      b     = 16'h5555;
      sel   = 1'b0;
      mdl_q = '0;
      mdl_v = 1'b0;

      // Combinational path while reset is held. The clock is running.
      #10 check("comb_aaaa", 32'(out), 32'h0000_AAAA);
      sel = 1'b1;
      #10 check("comb_5555", 32'(out), 32'h0000_5555);
      a = 16'hFFFF; b = 16'h0000; sel = 1'b0;
      #10 check("comb_ffff", 32'(out), 32'h0000_FFFF);
      sel = 1'b1;
      #10 check("comb_0000", 32'(out), 32'h0000_0000);
      check("rst_out_q", 32'(out_q), 32'h0);
      check("rst_out_valid", 32'(out_valid), 32'h0);

      // Random inputs with reset held. The register must stay cleared.
      for (int i = 0; i < 12; i++) begin
         a   = hack_word_t'($urandom);
         b   = hack_word_t'($urandom);
         sel = 1'($urandom);
         en  = 1'($urandom);
         #7;
         check("rst_comb", 32'(out), 32'(ref_mux(a, b, sel)));
         check("rst_hold_q", 32'(out_q), 32'h0);
         check("rst_hold_v", 32'(out_valid), 32'h0);
      end

      // Release reset, then run one directed capture.
      @(negedge clk);
      rst_n = 1'b1;
      a = 16'h1234; b = 16'hBEEF; sel = 1'b1; en = 1'b1;
      edge_model();
      @(negedge clk);
      check("cap_out_q", 32'(out_q), 32'h0000_BEEF);
      check("cap_valid", 32'(out_valid), 32'h1);
      en = 1'b0;
      a = 16'h0F0F; b = 16'hF0F0;
      edge_model();
      @(negedge clk);
      check("hold_out_q", 32'(out_q), 32'h0000_BEEF);
      check("hold_valid", 32'(out_valid), 32'h0);

      // Reset pulse between edges clears the register immediately.
      #1 rst_n = 1'b0;
      #1;
      check("pulse_out_q", 32'(out_q), 32'h0);
      check("pulse_valid", 32'(out_valid), 32'h0);
      check("pulse_comb", 32'(out), 32'(ref_mux(a, b, sel)));
      #1 rst_n = 1'b1;
      mdl_q = '0;
      mdl_v = 1'b0;

      // Random traffic. Hold and strobe are checked against the model every
      // cycle. Capture contents are checked by the monitor.
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         check("rnd_out_q", 32'(out_q), 32'(mdl_q));
         check("rnd_valid", 32'(out_valid), 32'(mdl_v));
         a   = hack_word_t'($urandom);
         b   = hack_word_t'($urandom);
         sel = 1'($urandom);
         en  = ($urandom_range(3, 0) != 0);
         #1 check("rnd_comb", 32'(out), 32'(ref_mux(a, b, sel)));
         edge_model();
      end

      en = 1'b0;
      repeat (3) @(negedge clk);
      check("queue_drained", 32'(exp_q.size()), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_mux_16
